// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checking chain.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam logic EVEN_PARITY    = 1'b0;
   localparam logic ODD_PARITY_SEL = 1'b1;

   // Map an integer parity-mode parameter onto the polarity bit.
   function automatic logic parity_sel(input int unsigned mode);
      return (mode != 0) ? ODD_PARITY_SEL : EVEN_PARITY;
   endfunction

endpackage

// File: rtl/parity_accum.sv
// One-bit running XOR register with synchronous clear and enable.
module parity_accum (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic parity
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         parity <= 1'b0;
      end else if (en) begin
         parity <= parity ^ bit_in;
      end
   end

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_W data bits (LSB first) plus a parity bit, flags parity
// errors and keeps a saturating count of failed frames.
module serial_parity_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ODD_PARITY = 0,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 abort,
   input  logic                 clr_err,
   output logic                 busy,
   output logic [DATA_W-1:0]    data_out,
   output logic                 parity_ok,
   output logic                 frame_valid,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
   localparam logic ODD_BIT = parity_sel(ODD_PARITY);

   state_t              state;
   logic [DATA_W-1:0]   shift_q;
   logic [DATA_W-1:0]   shift_nx;
   logic [CNT_W-1:0]    bit_cnt;
   logic                run_par;
   logic                acc_clr;
   logic                acc_en;
   logic                check;

   assign busy = (state != IDLE);

   // Accumulator clears on an accepted start and tracks only accepted data bits.
   assign acc_clr = (state == IDLE) && start;
   assign acc_en  = (state == DATA) && bit_valid && !abort;
   assign check   = run_par ^ bit_in ^ ODD_BIT;

   // New bit enters at the MSB so bit k ends up at position k after DATA_W shifts.
   always_comb begin
      shift_nx           = shift_q >> 1;
      shift_nx[DATA_W-1] = bit_in;
   end

   parity_accum u_accum (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .en     (acc_en),
      .bit_in (bit_in),
      .parity (run_par)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shift_q     <= '0;
         bit_cnt     <= '0;
         data_out    <= '0;
         parity_ok   <= 1'b0;
         frame_valid <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= DATA;
                  shift_q <= '0;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (abort) begin
                  state <= IDLE;
               end else if (bit_valid) begin
                  shift_q <= shift_nx;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (abort) begin
                  state <= IDLE;
               end else if (bit_valid) begin
                  state       <= IDLE;
                  data_out    <= shift_q;
                  parity_ok   <= ~check;
                  frame_valid <= 1'b1;
                  if (check && (err_count != ERR_MAX)) begin
                     err_count <= err_count + ERR_CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // Clear overrides any increment issued above in the same cycle.
         if (clr_err) begin
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: three checker configurations share one directed stimulus stream.
module tb_serial_parity_checker;

   logic clk = 1'b0;
   logic rst, start, bit_in, bit_valid, abort, clr_err;

   logic       busy_e, busy_o, busy_s;
   logic [7:0] dout_e, dout_o, dout_s;
   logic       pok_e, pok_o, pok_s;
   logic       fv_e, fv_o, fv_s;
   logic [7:0] ec_e, ec_o;
   logic [1:0] ec_s;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] d;
      logic       ok;
      int         e;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int   mc[3];
   int   mmax[3];
   logic odd_of[3];
   logic last_ok[3];
   logic [7:0] last_d;
   int   seq[5];

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(8)) u_even (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .abort(abort), .clr_err(clr_err), .busy(busy_e), .data_out(dout_e),
      .parity_ok(pok_e), .frame_valid(fv_e), .err_count(ec_e));

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1), .ERR_CNT_W(8)) u_odd (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .abort(abort), .clr_err(clr_err), .busy(busy_o), .data_out(dout_o),
      .parity_ok(pok_o), .frame_valid(fv_o), .err_count(ec_o));

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .abort(abort), .clr_err(clr_err), .busy(busy_s), .data_out(dout_s),
      .parity_ok(pok_s), .frame_valid(fv_s), .err_count(ec_s));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one presented frame against the head of that instance's queue.
   task automatic pop_cmp(input int id, input logic [7:0] d, input logic ok, input int e);
      exp_t x;
      int   sz;
      sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_frame_valid inst=%0d actual=1 expected=0", id);
      end else begin
         if (id == 0) x = q0.pop_front();
         else if (id == 1) x = q1.pop_front();
         else x = q2.pop_front();
         chk($sformatf("data_out[%0d]", id), 32'(d), 32'(x.d));
         chk($sformatf("parity_ok[%0d]", id), 32'(ok), 32'(x.ok));
         chk($sformatf("err_count[%0d]", id), 32'(e), 32'(x.e));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (fv_e) pop_cmp(0, dout_e, pok_e, int'(ec_e));
         if (fv_o) pop_cmp(1, dout_o, pok_o, int'(ec_o));
         if (fv_s) pop_cmp(2, dout_s, pok_s, int'(ec_s));
      end
   end

   task automatic push_expected(input logic [7:0] d, input logic p, input logic clr);
      exp_t x;
      for (int i = 0; i < 3; i++) begin
         x.d  = d;
         x.ok = ~((^d) ^ p ^ odd_of[i]);
         if (clr) mc[i] = 0;
         else if (!x.ok && mc[i] < mmax[i]) mc[i]++;
         x.e  = mc[i];
         last_ok[i] = x.ok;
         if (i == 0) q0.push_back(x);
         else if (i == 1) q1.push_back(x);
         else q2.push_back(x);
      end
      last_d = d;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input int gmax,
                             input logic clr, input logic bv_start, input logic ab_start);
      int g;
      start = 1'b1; abort = ab_start; bit_valid = bv_start; bit_in = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
      chk("fv_one_cycle", 32'({fv_s, fv_o, fv_e}), 32'd0);
      chk("busy_after_start", 32'({busy_s, busy_o, busy_e}), 32'h7);
      for (int k = 0; k < 8; k++) begin
         g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
         repeat (g) begin
            bit_valid = 1'b0;
            start     = 1'b1;
            tick();
         end
         start = 1'b0; bit_valid = 1'b1; bit_in = d[k];
         tick();
      end
      bit_valid = 1'b1; bit_in = p; clr_err = clr;
      push_expected(d, p, clr);
      tick();
      bit_valid = 1'b0; clr_err = 1'b0;
      chk("fv_latency", 32'({fv_s, fv_o, fv_e}), 32'h7);
      chk("busy_after_parity", 32'({busy_s, busy_o, busy_e}), 32'd0);
   endtask

   task automatic aborted_frame(input int nbits);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      abort = 1'b0; bit_valid = 1'b0;
      chk("busy_after_abort", 32'({busy_s, busy_o, busy_e}), 32'd0);
      chk("dout_hold_abort", 32'(dout_e), 32'(last_d));
      chk("pok_hold_abort", 32'({pok_s, pok_o, pok_e}),
          32'({last_ok[2], last_ok[1], last_ok[0]}));
      repeat (3) tick();
   endtask

   initial begin
      mmax   = '{255, 255, 3};
      odd_of = '{1'b0, 1'b1, 1'b0};
      seq    = '{1, 2, 3, 3, 3};
      mc     = '{0, 0, 0};
      last_d = 8'h00;
      last_ok = '{1'b0, 1'b0, 1'b0};
      rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
      abort = 1'b0; clr_err = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_busy", 32'({busy_s, busy_o, busy_e}), 32'd0);
      chk("reset_dout", 32'({dout_s, dout_o, dout_e}), 32'd0);
      chk("reset_pok_fv", 32'({pok_s, pok_o, pok_e, fv_s, fv_o, fv_e}), 32'd0);
      chk("reset_err", 32'({ec_s, ec_o, ec_e}), 32'd0);
      tick();

      // Even/odd directed frames; first one also drives bit_valid with start.
      send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      chk("a5_err_even", 32'(ec_e), 32'd0);
      send_frame(8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("01p0_err_even", 32'(ec_e), 32'd1);
      send_frame(8'h01, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      chk("01p1_err_even", 32'(ec_e), 32'd1);
      send_frame(8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      chk("00p1_odd_ok", 32'(pok_o), 32'd1);
      send_frame(8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("00p0_odd_ok", 32'(pok_o), 32'd0);

      // Abort in DATA after 4 bits, then in PARITY; then abort+start in IDLE.
      aborted_frame(4);
      aborted_frame(8);
      send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0, 1'b1);

      send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 5, 1'b0, 1'b0, 1'b0);
      chk("gap_5a_dout", 32'(dout_e), 32'h5A);

      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      mc = '{0, 0, 0};
      chk("clr_err_standalone", 32'({ec_s, ec_o, ec_e}), 32'd0);

      for (int i = 0; i < 5; i++) begin
         send_frame(8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("sat_seq_%0d", i), 32'(ec_s), 32'(seq[i]));
      end
      send_frame(8'h01, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("clr_wins_inc", 32'({ec_s, ec_o, ec_e}), 32'd0);

      // Reset in the middle of a frame.
      send_frame(8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      bit_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      mc = '{0, 0, 0};
      chk("midrst_busy", 32'({busy_s, busy_o, busy_e}), 32'd0);
      chk("midrst_dout", 32'({dout_s, dout_o, dout_e}), 32'd0);
      chk("midrst_pok_fv", 32'({pok_s, pok_o, pok_e, fv_s, fv_o, fv_e}), 32'd0);
      chk("midrst_err", 32'({ec_s, ec_o, ec_e}), 32'd0);

      repeat (4) tick();
      chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
